// File: rtl/hash_round_core.sv
// Iterative SHA-256/SHA-512 compression engine: one round per accepted W_t/K_t beat,
// then the saved chaining value is added back to form the registered block digest.
module hash_round_core #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    data_width_flag,
  input  logic                    start,
  input  logic [8*DATA_WIDTH-1:0] h_in,
  input  logic                    wk_valid,
  output logic                    wk_ready,
  input  logic [DATA_WIDTH-1:0]   w_value,
  input  logic [DATA_WIDTH-1:0]   k_value,
  output logic                    busy,
  output logic [8*DATA_WIDTH-1:0] digest_out,
  output logic                    digest_valid
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned NW = 8;
  localparam int unsigned TW = 7;
  localparam logic [TW-1:0] LAST_T32 = TW'(63);
  localparam logic [TW-1:0] LAST_T64 = TW'(79);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [TW-1:0]    t_q, t_d;
  logic [DW-1:0]    wv_q [NW];
  logic [DW-1:0]    wv_d [NW];
  logic [DW-1:0]    hs_q [NW];
  logic [DW-1:0]    hs_d [NW];
  logic [NW*DW-1:0] digest_q, digest_d;
  logic             dv_q, dv_d;

  logic [DW-1:0] w_in, k_in, sig0, sig1, ch, maj, t1, t2;
  logic [TW-1:0] last_t;

  // Narrow mode keeps only the low 32 bits of every word.
  function automatic logic [DW-1:0] fit(input logic wide, input logic [DW-1:0] x);
    return wide ? x : DW'(x[31:0]);
  endfunction

  function automatic logic [DW-1:0] rotr_w(input logic [DW-1:0] x, input int unsigned n);
    return (x >> n) | (x << (DW - n));
  endfunction

  function automatic logic [31:0] rotr_n(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Single-round datapath on the current working variables a..h = wv_q[0..7].
  always_comb begin
    w_in = fit(mode_q, w_value);
    k_in = fit(mode_q, k_value);
    if (mode_q) begin
      sig0 = rotr_w(wv_q[0], 28) ^ rotr_w(wv_q[0], 34) ^ rotr_w(wv_q[0], 39);
      sig1 = rotr_w(wv_q[4], 14) ^ rotr_w(wv_q[4], 18) ^ rotr_w(wv_q[4], 41);
    end else begin
      sig0 = DW'(rotr_n(wv_q[0][31:0], 2) ^ rotr_n(wv_q[0][31:0], 13) ^ rotr_n(wv_q[0][31:0], 22));
      sig1 = DW'(rotr_n(wv_q[4][31:0], 6) ^ rotr_n(wv_q[4][31:0], 11) ^ rotr_n(wv_q[4][31:0], 25));
    end
    ch  = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
    maj = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
    t1  = fit(mode_q, wv_q[7] + sig1 + ch + k_in + w_in);
    t2  = fit(mode_q, sig0 + maj);
    last_t = mode_q ? LAST_T64 : LAST_T32;
  end

  // Next-state logic for control, working variables and digest.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    t_d      = t_q;
    wv_d     = wv_q;
    hs_d     = hs_q;
    digest_d = digest_q;
    dv_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ROUND;
          mode_d  = data_width_flag;
          t_d     = '0;
          for (int unsigned i = 0; i < NW; i++) begin
            wv_d[i] = fit(data_width_flag, h_in[i*DW +: DW]);
            hs_d[i] = fit(data_width_flag, h_in[i*DW +: DW]);
          end
        end
      end
      S_ROUND: begin
        if (wk_valid) begin
          wv_d[7] = wv_q[6];
          wv_d[6] = wv_q[5];
          wv_d[5] = wv_q[4];
          wv_d[4] = fit(mode_q, wv_q[3] + t1);
          wv_d[3] = wv_q[2];
          wv_d[2] = wv_q[1];
          wv_d[1] = wv_q[0];
          wv_d[0] = fit(mode_q, t1 + t2);
          t_d     = t_q + 1'b1;
          if (t_q == last_t) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        for (int unsigned i = 0; i < NW; i++) begin
          digest_d[i*DW +: DW] = fit(mode_q, hs_q[i] + wv_q[i]);
        end
        dv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      t_q      <= '0;
      digest_q <= '0;
      dv_q     <= 1'b0;
      for (int unsigned i = 0; i < NW; i++) begin
        wv_q[i] <= '0;
        hs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      t_q      <= t_d;
      digest_q <= digest_d;
      dv_q     <= dv_d;
      for (int unsigned i = 0; i < NW; i++) begin
        wv_q[i] <= wv_d[i];
        hs_q[i] <= hs_d[i];
      end
    end
  end

  // wk_ready depends only on state so upstream can never form a loop through it.
  assign wk_ready     = (state_q == S_ROUND);
  assign busy         = (state_q != S_IDLE);
  assign digest_out   = digest_q;
  assign digest_valid = dv_q;

endmodule
